coeff_readback_axi: RTL and testbench

AXI4-Lite read-channel responder that returns the current 5x5 FIR coefficient set to the MicroBlaze. It sits beside the coefficient write path: its coefficient inputs connect to the same coeff00..coeff44 nets that drive the filter, so software can verify what it programmed. It also serves a fixed kernel-ID word and a free-running completed-read counter.

---
 rtl/coeff_readback_axi.sv | 162 ++++++++++++++++
 tb/tb_coeff_readback_axi.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_readback_axi.sv
// AXI4-Lite read-only responder exposing the live 5x5 FIR coefficient set,
// a fixed kernel-ID word and a counter of completed read responses.
module coeff_readback_axi #(
    parameter int unsigned ADDR_BITS = 8,
    parameter logic [31:0] KERNEL_ID = 32'h0000_0505
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        s_axi_araddr,
    input  logic               s_axi_arvalid,
    output logic               s_axi_arready,
    output logic [31:0]        s_axi_rdata,
    output logic [1:0]         s_axi_rresp,
    output logic               s_axi_rvalid,
    input  logic               s_axi_rready,
    input  logic signed [15:0] coeff00,
    input  logic signed [15:0] coeff01,
    input  logic signed [15:0] coeff02,
    input  logic signed [15:0] coeff03,
    input  logic signed [15:0] coeff04,
    input  logic signed [15:0] coeff10,
    input  logic signed [15:0] coeff11,
    input  logic signed [15:0] coeff12,
    input  logic signed [15:0] coeff13,
    input  logic signed [15:0] coeff14,
    input  logic signed [15:0] coeff20,
    input  logic signed [15:0] coeff21,
    input  logic signed [15:0] coeff22,
    input  logic signed [15:0] coeff23,
    input  logic signed [15:0] coeff24,
    input  logic signed [15:0] coeff30,
    input  logic signed [15:0] coeff31,
    input  logic signed [15:0] coeff32,
    input  logic signed [15:0] coeff33,
    input  logic signed [15:0] coeff34,
    input  logic signed [15:0] coeff40,
    input  logic signed [15:0] coeff41,
    input  logic signed [15:0] coeff42,
    input  logic signed [15:0] coeff43,
    input  logic signed [15:0] coeff44
);

    localparam int unsigned WORD_W    = ADDR_BITS - 2;
    localparam int unsigned NCOEF     = 25;
    localparam int unsigned W_ID      = 25;
    localparam int unsigned W_COUNT   = 26;
    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam logic [1:0]  RESP_SERR = 2'b10;

    localparam logic [1:0] ST_INIT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [31:0]       rd_count_q;
    logic              r_hs_c;
    logic [WORD_W-1:0] word_c;
    logic [31:0]       dec_data_c;
    logic [1:0]        dec_resp_c;
    logic signed [15:0] coeff_a [NCOEF];
    logic              unused_addr;

    // Row-major flattening: word index k maps to row k/5, column k%5
    assign coeff_a = '{coeff00, coeff01, coeff02, coeff03, coeff04,
                       coeff10, coeff11, coeff12, coeff13, coeff14,
                       coeff20, coeff21, coeff22, coeff23, coeff24,
                       coeff30, coeff31, coeff32, coeff33, coeff34,
                       coeff40, coeff41, coeff42, coeff43, coeff44};

    assign word_c      = s_axi_araddr[ADDR_BITS-1:2];
    assign unused_addr = ^{s_axi_araddr[31:ADDR_BITS], s_axi_araddr[1:0]};
    assign r_hs_c      = rvalid_q & s_axi_rready;

    // Address decode; upper address bits are ignored so the map aliases
    always_comb begin
        dec_data_c = 32'h0;
        dec_resp_c = RESP_SERR;
        if (word_c == WORD_W'(W_ID)) begin
            dec_data_c = KERNEL_ID;
            dec_resp_c = RESP_OKAY;
        end else if (word_c == WORD_W'(W_COUNT)) begin
            dec_data_c = rd_count_q;
            dec_resp_c = RESP_OKAY;
        end
        for (int k = 0; k < NCOEF; k++) begin
            if (word_c == WORD_W'(k)) begin
                dec_data_c = 32'(coeff_a[k]);
                dec_resp_c = RESP_OKAY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_INIT;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Next state plus the registered handshake outputs for that state
    always_comb begin
        state_d   = state_q;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (state_q)
            ST_INIT: begin
                state_d   = ST_IDLE;
                arready_d = 1'b1;
            end
            ST_IDLE: begin
                if (s_axi_arvalid) begin
                    state_d  = ST_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = dec_data_c;
                    rresp_d  = dec_resp_c;
                end else begin
                    arready_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (s_axi_rready) begin
                    state_d   = ST_IDLE;
                    arready_d = 1'b1;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_count_q <= 32'h0;
        end else if (r_hs_c) begin
            rd_count_q <= rd_count_q + 32'd1;
        end
    end

    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_coeff_readback_axi.sv
// Self-checking bench for coeff_readback_axi: directed plan plus randomized reads
// against an address-map reference model.
module tb_coeff_readback_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] araddr = 32'h0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic signed [15:0] cm [5][5];

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mcount = 32'h0;

    always #5 clk = ~clk;

    coeff_readback_axi dut (
        .clk(clk), .rst(rst),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
        .s_axi_rready(rready),
        .coeff00(cm[0][0]), .coeff01(cm[0][1]), .coeff02(cm[0][2]), .coeff03(cm[0][3]), .coeff04(cm[0][4]),
        .coeff10(cm[1][0]), .coeff11(cm[1][1]), .coeff12(cm[1][2]), .coeff13(cm[1][3]), .coeff14(cm[1][4]),
        .coeff20(cm[2][0]), .coeff21(cm[2][1]), .coeff22(cm[2][2]), .coeff23(cm[2][3]), .coeff24(cm[2][4]),
        .coeff30(cm[3][0]), .coeff31(cm[3][1]), .coeff32(cm[3][2]), .coeff33(cm[3][3]), .coeff34(cm[3][4]),
        .coeff40(cm[4][0]), .coeff41(cm[4][1]), .coeff42(cm[4][2]), .coeff43(cm[4][3]), .coeff44(cm[4][4])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: {rresp, rdata} for an address given the current coefficients and count
    function automatic logic [33:0] model(input logic [31:0] a);
        int w;
        w = int'(a % 256) / 4;
        if (w < 25) return {2'b00, 32'(int'(cm[w / 5][w % 5]))};
        if (w == 25) return {2'b00, 32'h0000_0505};
        if (w == 26) return {2'b00, mcount};
        return {2'b10, 32'h0};
    endfunction

    task automatic randomize_coeffs();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                cm[r][c] = 16'($urandom);
    endtask

    // One complete read; delay = cycles of rready low; mutate = scramble coeffs while waiting
    task automatic do_read(input logic [31:0] addr, input int delay, input bit mutate);
        logic [33:0] exp;
        int t;
        @(negedge clk);
        araddr  = addr;
        arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!arready) begin
            check("ar_timeout", 32'(arready), 32'd1);
            arvalid = 1'b0;
            return;
        end
        exp = model(addr);
        @(negedge clk);
        arvalid = 1'b0;
        for (int i = 0; i < delay; i++) begin
            check("rvalid_hold", 32'(rvalid), 32'd1);
            check("rdata_hold", rdata, exp[31:0]);
            if (mutate) randomize_coeffs();
            @(negedge clk);
        end
        check("rvalid", 32'(rvalid), 32'd1);
        check("arready_busy", 32'(arready), 32'd0);
        check("rdata", rdata, exp[31:0]);
        check("rresp", 32'(rresp), 32'(exp[33:32]));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        mcount = mcount + 32'd1;
        check("rvalid_drop", 32'(rvalid), 32'd0);
        check("arready_back", 32'(arready), 32'd1);
    endtask

    initial begin
        int hs;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                cm[r][c] = {4'(r), 4'(c), 8'h01};
        cm[2][3] = 16'hFFFD;

        // Reset held with arvalid asserted
        arvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("rst_arready", 32'(arready), 32'd0);
            check("rst_rvalid", 32'(rvalid), 32'd0);
        end
        rst = 1'b1;
        arvalid = 1'b0;
        #1 check("init_arready", 32'(arready), 32'd0);
        @(negedge clk);
        check("idle_arready", 32'(arready), 32'd1);
        check("idle_rdata", rdata, 32'h0);
        check("idle_rresp", 32'(rresp), 32'd0);
        check("idle_rvalid", 32'(rvalid), 32'd0);

        // Full coefficient map
        for (int k = 0; k < 25; k++) do_read(32'(k * 4), 0, 1'b0);
        check("coeff23_const", 32'(int'(cm[2][3])), 32'hFFFF_FFFD);
        do_read(32'h64, 0, 1'b0);
        check("count_before_0x68", mcount, 32'd26);
        do_read(32'h68, 0, 1'b0);
        do_read(32'h6C, 0, 1'b0);
        do_read(32'hFC, 0, 1'b0);
        check("count_before_2nd_0x68", mcount, 32'd29);
        do_read(32'h68, 0, 1'b0);

        // Backpressure with snapshot and held arvalid
        @(negedge clk);
        cm[0][0] = 16'sd5;
        araddr   = 32'h0;
        arvalid  = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata", rdata, 32'd5);
            check("bp_arready", 32'(arready), 32'd0);
            if (i == 2) cm[0][0] = 16'sd9;
            @(negedge clk);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        mcount = mcount + 32'd1;
        check("bp_rvalid_drop", 32'(rvalid), 32'd0);
        check("bp_arready_back", 32'(arready), 32'd1);
        @(negedge clk);
        arvalid = 1'b0;
        check("bp_second_rvalid", 32'(rvalid), 32'd1);
        check("bp_second_rdata", rdata, 32'd9);
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        mcount = mcount + 32'd1;

        // Back-to-back reads of the counter
        araddr  = 32'h68;
        arvalid = 1'b1;
        rready  = 1'b1;
        hs = 0;
        for (int i = 0; i < 20; i++) begin
            check("b2b_overlap", 32'(arready & rvalid), 32'd0);
            check("b2b_arready_alt", 32'(arready), 32'((i % 2) == 0));
            if (rvalid) begin
                check("b2b_rdata", rdata, mcount);
                mcount = mcount + 32'd1;
                hs++;
            end
            @(negedge clk);
        end
        arvalid = 1'b0;
        rready  = 1'b0;
        check("b2b_handshakes", 32'(hs), 32'd10);

        // Randomized reads with backpressure and coefficient churn
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            randomize_coeffs();
            if ($urandom_range(0, 2) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 27) * 4) | 32'($urandom_range(0, 3));
            do_read(a, int'($urandom_range(0, 3)), 1'b1);
        end

        // Reset in the middle of a pending response
        @(negedge clk);
        araddr  = 32'h68;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
        check("mid_rvalid", 32'(rvalid), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check("mid_rst_arready", 32'(arready), 32'd0);
        rready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_hold_rvalid", 32'(rvalid), 32'd0);
        end
        rst = 1'b1;
        mcount = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_rvalid", 32'(rvalid), 32'd0);
        end
        rready = 1'b0;
        do_read(32'h68, 0, 1'b0);

        // Counter wrap
        @(negedge clk);
        dut.rd_count_q = 32'hFFFF_FFFF;
        mcount = 32'hFFFF_FFFF;
        do_read(32'h0, 0, 1'b0);
        check("wrap_model", mcount, 32'h0);
        do_read(32'h68, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
